index_vector_builder: RTL and testbench

- Inverse of the first-one index stage: rebuilds a DOUT_WIDTH-bit hit bitmap from a stream of bit indices.
- Each valid index sets its bit in an accumulator. A frame closes after FRAME_LEN valid beats or on din_last.
- The closed bitmap moves to an output holding register, which is drained through a valid/ready handshake.
- Used after the detection/timestamp path to reassemble per-frame channel hit masks for readout.

---
 rtl/index_vector_builder.sv | 174 +++++++++++++++++
 tb/tb_index_vector_builder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/index_vector_builder.sv
// -----------------------------------------------------------------------------
// index_vector_builder
//
// Rebuilds a DOUT_WIDTH-bit hit bitmap from a stream of bit indices. This is
// the inverse of a first-one index stage. Each valid index sets its bit in an
// accumulator. A frame closes after FRAME_LEN valid beats, or when din_last is
// seen. A closed frame moves to an output holding register, and a
// valid/ready handshake drains that register. The accumulator never stalls.
// When a frame closes while the holding register is full and not draining,
// the new frame is dropped and the sticky overflow flag is set.
//
// Optional feature: define DUP_DETECT_EN to add dout_dup. This flag reports
// whether any in-range index in the frame hit a bit that was already set
// earlier in the same frame.
//
// Ports:
//   clk         in   system clock, all logic on posedge
//   rst         in   synchronous active-high reset
//   din         in   bit index to set
//   din_valid   in   din is a valid beat this cycle
//   din_last    in   close the current frame (with or without din_valid)
//   dout        out  completed frame bitmap
//   dout_hits   out  valid beats in the frame (duplicates/out-of-range included)
//   dout_valid  out  holding register contains a frame
//   dout_ready  in   consumer accepts the frame when dout_valid && dout_ready
//   overflow    out  sticky: at least one completed frame was dropped
//   dout_dup    out  (DUP_DETECT_EN only) frame contained a repeated index
// -----------------------------------------------------------------------------
module index_vector_builder #(
    parameter int DOUT_WIDTH = 32,
    parameter int DIN_WIDTH  = $clog2(DOUT_WIDTH),
    parameter int FRAME_LEN  = 16,
    parameter int CNT_WIDTH  = $clog2(FRAME_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic                  din_valid,
    input  logic                  din_last,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic [CNT_WIDTH-1:0]  dout_hits,
    output logic                  dout_valid,
    input  logic                  dout_ready,
`ifdef DUP_DETECT_EN
    output logic                  dout_dup,
`endif
    output logic                  overflow
);

    typedef enum logic {EMPTY, ACCUM} state_t;

    // Counter value that, on a further valid beat, completes a full frame.
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(FRAME_LEN - 1);

    state_t                  state_q, state_d;
    logic [DOUT_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;

    logic [DOUT_WIDTH-1:0]   hold_q;
    logic [CNT_WIDTH-1:0]    hold_hits_q;
    logic                    hold_vld_q;
    logic                    ovf_q;

    logic                    in_range;
    logic [DOUT_WIDTH-1:0]   hit_mask;
    logic [DOUT_WIDTH-1:0]   acc_next;
    logic [CNT_WIDTH-1:0]    cnt_next;
    logic                    frame_close;
    logic                    hold_load;

`ifdef DUP_DETECT_EN
    logic                    dup_q, dup_d, dup_next;
    logic                    hold_dup_q;
`endif

    // When DOUT_WIDTH is not a power of two, an index can point past the
    // bitmap. Such a beat is still counted, but it sets no bit.
    assign in_range = int'(din) < DOUT_WIDTH;
    assign hit_mask = in_range ? (DOUT_WIDTH'(1) << din) : '0;

    // Frame contents including the current beat. Both the close path and the
    // continue path use these values.
    assign acc_next = din_valid ? (acc_q | hit_mask) : acc_q;
    assign cnt_next = din_valid ? (cnt_q + CNT_WIDTH'(1)) : cnt_q;

    // A lone din_last on an empty accumulator is ignored. Empty frames are
    // never emitted.
    assign frame_close = (din_valid && (cnt_q == LAST_CNT)) ||
                         (din_last && ((cnt_q != '0) || din_valid));

    // The holding register accepts a frame if it is free, or if it is being
    // drained in this same cycle.
    assign hold_load = frame_close && (!hold_vld_q || dout_ready);

`ifdef DUP_DETECT_EN
    assign dup_next = dup_q | (din_valid && in_range && ((acc_q & hit_mask) != '0));
`endif

    // Accumulator FSM: next-state logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_next;
        cnt_d   = cnt_next;
`ifdef DUP_DETECT_EN
        dup_d   = dup_next;
`endif
        if (frame_close) begin
            state_d = EMPTY;
            acc_d   = '0;
            cnt_d   = '0;
`ifdef DUP_DETECT_EN
            dup_d   = 1'b0;
`endif
        end else if (din_valid) begin
            state_d = ACCUM;
        end
    end

    // Accumulator FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            acc_q   <= '0;
            cnt_q   <= '0;
`ifdef DUP_DETECT_EN
            dup_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
`ifdef DUP_DETECT_EN
            dup_q   <= dup_d;
`endif
        end
    end

    // Output holding register. Its data holds its value after a drain, so
    // dout and dout_hits keep the last frame while dout_valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= '0;
            hold_hits_q <= '0;
            hold_vld_q  <= 1'b0;
            ovf_q       <= 1'b0;
`ifdef DUP_DETECT_EN
            hold_dup_q  <= 1'b0;
`endif
        end else begin
            if (hold_load) begin
                hold_q      <= acc_next;
                hold_hits_q <= cnt_next;
                hold_vld_q  <= 1'b1;
`ifdef DUP_DETECT_EN
                hold_dup_q  <= dup_next;
`endif
            end else if (hold_vld_q && dout_ready) begin
                hold_vld_q  <= 1'b0;
            end
            if (frame_close && !hold_load) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign dout       = hold_q;
    assign dout_hits  = hold_hits_q;
    assign dout_valid = hold_vld_q;
    assign overflow   = ovf_q;
`ifdef DUP_DETECT_EN
    assign dout_dup   = hold_dup_q;
`endif

endmodule

// File: tb/tb_index_vector_builder.sv
// -----------------------------------------------------------------------------
// tb_index_vector_builder
//
// Directed-vector bench for index_vector_builder with default parameters.
// Inputs change 1 ns after each rising edge. Outputs are sampled at that same
// point, after the edge that captured the previous inputs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_index_vector_builder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  din = '0;
    logic        din_valid = 1'b0;
    logic        din_last = 1'b0;
    logic [31:0] dout;
    logic [4:0]  dout_hits;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        overflow;
`ifdef DUP_DETECT_EN
    logic        dout_dup;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    index_vector_builder dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_last   (din_last),
        .dout       (dout),
        .dout_hits  (dout_hits),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
`ifdef DUP_DETECT_EN
        .dout_dup   (dout_dup),
`endif
        .overflow   (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic beat(input logic [4:0] idx, input logic last);
        din       = idx;
        din_valid = 1'b1;
        din_last  = last;
        tick();
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_dout",  dout,       32'h0);
        chk("rst_hits",  {27'd0, dout_hits}, 32'd0);
        chk("rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("rst_ovf",   {31'd0, overflow},   32'd0);
        rst = 1'b0;

        // 1: full frame of 16 beats closes automatically
        dout_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("t1_not_early", {31'd0, dout_valid}, 32'd0);
            beat(5'(i), 1'b0);
        end
        chk("t1_dout",  dout,       32'h0000FFFF);
        chk("t1_hits",  {27'd0, dout_hits}, 32'd16);
        chk("t1_valid", {31'd0, dout_valid}, 32'd1);
        tick();
        chk("t1_drain", {31'd0, dout_valid}, 32'd0);
        chk("t1_hold",  dout,       32'h0000FFFF);

        // 2: close on din_last without a valid beat; lone din_last is ignored
        beat(5'd3, 1'b0);
        beat(5'd31, 1'b0);
        din_last = 1'b1;
        tick();
        din_last = 1'b0;
        chk("t2_dout",  dout,       32'h80000008);
        chk("t2_hits",  {27'd0, dout_hits}, 32'd2);
        chk("t2_valid", {31'd0, dout_valid}, 32'd1);
        din_last = 1'b1;
        tick();
        din_last = 1'b0;
        chk("t2_lone_last", {31'd0, dout_valid}, 32'd0);
        tick();
        chk("t2_no_frame",  {31'd0, dout_valid}, 32'd0);

        // 3: back-pressure drops the second frame
        dout_ready = 1'b0;
        beat(5'd5, 1'b1);
        chk("t3_first", dout, 32'h00000020);
        beat(5'd7, 1'b1);
        chk("t3_dout",  dout,       32'h00000020);
        chk("t3_hits",  {27'd0, dout_hits}, 32'd1);
        chk("t3_ovf",   {31'd0, overflow},   32'd1);
        chk("t3_valid", {31'd0, dout_valid}, 32'd1);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        chk("t3_drain", {31'd0, dout_valid}, 32'd0);
        chk("t3_sticky", {31'd0, overflow},  32'd1);

        // 4: drain and load in the same cycle
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4_ovf_clr", {31'd0, overflow}, 32'd0);
        beat(5'd2, 1'b1);
        tick();
        chk("t4_stable", dout, 32'h00000004);
        chk("t4_stable_v", {31'd0, dout_valid}, 32'd1);
        dout_ready = 1'b1;
        beat(5'd9, 1'b1);
        dout_ready = 1'b0;
        chk("t4_dout",  dout,       32'h00000200);
        chk("t4_valid", {31'd0, dout_valid}, 32'd1);
        chk("t4_hits",  {27'd0, dout_hits}, 32'd1);
        chk("t4_ovf",   {31'd0, overflow},   32'd0);

        // 5: reset mid-frame discards partial frame
        dout_ready = 1'b1;
        tick();
        beat(5'd0, 1'b0);
        beat(5'd1, 1'b0);
        beat(5'd2, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_dout",  dout, 32'h0);
        chk("t5_rst_valid", {31'd0, dout_valid}, 32'd0);
        chk("t5_rst_hits",  {27'd0, dout_hits}, 32'd0);
        for (int i = 0; i < 16; i++) beat(5'(i + 16), 1'b0);
        chk("t5_dout",  dout,       32'hFFFF0000);
        chk("t5_hits",  {27'd0, dout_hits}, 32'd16);
        chk("t5_valid", {31'd0, dout_valid}, 32'd1);
        tick();

`ifdef DUP_DETECT_EN
        // 6: duplicate detection
        beat(5'd4, 1'b0);
        beat(5'd4, 1'b0);
        din_last = 1'b1;
        tick();
        din_last = 1'b0;
        chk("t6_dout", dout, 32'h00000010);
        chk("t6_hits", {27'd0, dout_hits}, 32'd2);
        chk("t6_dup",  {31'd0, dout_dup},  32'd1);
        beat(5'd1, 1'b0);
        beat(5'd2, 1'b1);
        chk("t6_dout2", dout, 32'h00000006);
        chk("t6_dup2",  {31'd0, dout_dup}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
